// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, drives a 1-cycle synchronous program ROM, and
//   buffers returned words in a prefetch FIFO ahead of the single-cycle datapath.
// Latency: reset release / redirect edge E -> ROM issue at E+1, push at E+2, head valid after E+2.
// Backpressure: inst_valid/inst_ready handshake; with inst_ready low the head holds, the FIFO
//   fills and issue stops once occupied + in-flight words reach FIFO_DEPTH (no word is dropped).
// Ports: clk/rst (async, active-low); mem_addr/mem_q ROM interface; redirect/redirect_pc
//   new fetch target with flush; inst_valid/inst_ready/instruction/inst_pc/inst_pc_plus4
//   head entry; fifo_count occupancy; misaligned one-cycle pulse on an unaligned redirect;
//   starve_cnt cycles the datapath was ready but had nothing (built only with
//   FETCH_STARVE_CNT_EN defined, otherwise tied to 0).
module fetch_unit #(
  parameter int          BIT_WIDTH      = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          MEM_ADDR_WIDTH = 6,
  parameter int          FIFO_DEPTH     = 4,
  parameter int unsigned RESET_PC       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  input  logic [BIT_WIDTH-1:0]        mem_q,
  input  logic                        redirect,
  input  logic [ADDR_WIDTH-1:0]       redirect_pc,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic [BIT_WIDTH-1:0]        instruction,
  output logic [ADDR_WIDTH-1:0]       inst_pc,
  output logic [ADDR_WIDTH-1:0]       inst_pc_plus4,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        misaligned,
  output logic [31:0]                 starve_cnt
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fpc;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic                  pend_v;

  logic [BIT_WIDTH-1:0]  inst_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;

  logic issue;
  logic push;
  logic pop;

  // Credit counts the in-flight word too, so a returning word always has a slot.
  // A same-cycle pop is deliberately not counted as credit.
  assign issue = !redirect && ((count + {{PW{1'b0}}, pend_v}) < DEPTH_C);
  assign push  = pend_v && !redirect;
  assign pop   = inst_valid && inst_ready;

  assign mem_addr   = fpc[MEM_ADDR_WIDTH+1:2];
  assign fifo_count = count;
  assign inst_valid = (count != '0);

  // Empty FIFO presents an all-zero NOP rather than stale storage.
  assign instruction   = inst_valid ? inst_mem[rd_ptr] : '0;
  assign inst_pc       = inst_valid ? pc_mem[rd_ptr] : '0;
  assign inst_pc_plus4 = inst_valid ? (pc_mem[rd_ptr] + ADDR_WIDTH'(4)) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc        <= ADDR_WIDTH'(RESET_PC);
      pend_pc    <= '0;
      pend_v     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= redirect && (|redirect_pc[1:0]);
      if (redirect) begin
        // Flush everything buffered and squash the word already in the ROM pipe.
        fpc    <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        pend_v <= 1'b0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (issue) begin
          pend_v  <= 1'b1;
          pend_pc <= fpc;
          fpc     <= fpc + ADDR_WIDTH'(4);
        end else begin
          pend_v  <= 1'b0;
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + (PW+1)'(1);
          2'b01:   count <= count - (PW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= mem_q;
      pc_mem[wr_ptr]   <= pend_pc;
    end
  end

`ifdef FETCH_STARVE_CNT_EN
  logic [31:0] starve_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (inst_ready && !inst_valid && (starve_q != 32'hFFFF_FFFF)) begin
      starve_q <= starve_q + 32'd1;
    end
  end

  assign starve_cnt = starve_q;
`else
  assign starve_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit against a ROM whose word n holds
// 32'h1000_0000+n. A stream-level model (next PC the datapath must receive, expected
// starve count and misaligned pulse) is checked every cycle, plus literal checkpoints.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  mem_addr;
  logic [31:0] mem_q;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic [2:0]  fifo_count;
  logic        misaligned;
  logic [31:0] starve_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // stream-level model state
  logic [31:0] exp_pc;
  logic [31:0] exp_starve;
  logic        exp_mis;

  fetch_unit #(
    .BIT_WIDTH(32), .ADDR_WIDTH(32), .MEM_ADDR_WIDTH(6), .FIFO_DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_q(mem_q),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
    .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4), .fifo_count(fifo_count),
    .misaligned(misaligned), .starve_cnt(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous ROM, 1-cycle read latency
  initial mem_q = 32'h0;
  always @(posedge clk) mem_q <= 32'h1000_0000 + {26'b0, mem_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] starve_exp(input logic [31:0] v);
`ifdef FETCH_STARVE_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // per-cycle compare against the stream model
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst) begin
        chk("m_rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("m_rst_count", {29'b0, fifo_count}, 32'd0);
        chk("m_rst_starve", starve_cnt, 32'd0);
        exp_pc     = 32'd0;
        exp_starve = 32'd0;
        exp_mis    = 1'b0;
      end else begin
        chk("m_valid_vs_count", {31'b0, inst_valid}, {31'b0, fifo_count != 3'd0});
        chk("m_count_le_depth", {31'b0, fifo_count <= 3'd4}, 32'd1);
        chk("m_misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
        chk("m_starve", starve_cnt, exp_starve);
        if (inst_valid) begin
          chk("m_head_pc", inst_pc, exp_pc);
          chk("m_head_inst", instruction, 32'h1000_0000 + ((inst_pc >> 2) & 32'd63));
          chk("m_head_pc4", inst_pc_plus4, inst_pc + 32'd4);
        end else begin
          chk("m_nop_inst", instruction, 32'd0);
          chk("m_nop_pc", inst_pc | inst_pc_plus4, 32'd0);
        end
        // what the coming edge must do to the stream
        exp_mis = redirect && (redirect_pc[1:0] != 2'b00);
        if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
        else if (inst_valid && inst_ready) exp_pc = exp_pc + 32'd4;
`ifdef FETCH_STARVE_CNT_EN
        if (inst_ready && !inst_valid && exp_starve != 32'hFFFF_FFFF) exp_starve = exp_starve + 32'd1;
`endif
      end
    end
  end

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b1;
    exp_pc = 32'd0; exp_starve = 32'd0; exp_mis = 1'b0;
    chk_en = 1;

    // ---- reset state, then streaming with ready=1
    repeat (3) tick();
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_count", {29'b0, fifo_count}, 32'd0);
    chk("rst_mem_addr", {26'b0, mem_addr}, 32'd0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_starve", starve_cnt, 32'd0);
    rst = 1'b1;
    tick();  // edge 1: issue
    chk("e1_valid", {31'b0, inst_valid}, 32'd0);
    chk("e1_mem_addr", {26'b0, mem_addr}, 32'd1);
    tick();  // edge 2: push
    chk("e2_valid", {31'b0, inst_valid}, 32'd1);
    chk("e2_pc", inst_pc, 32'd0);
    chk("e2_inst", instruction, 32'h1000_0000);
    chk("e2_pc4", inst_pc_plus4, 32'd4);
    chk("e2_starve", starve_cnt, starve_exp(32'd2));
    tick();
    chk("e3_pc", inst_pc, 32'd4);
    chk("e3_inst", instruction, 32'h1000_0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stream_no_gap", {31'b0, inst_valid}, 32'd1);
    end

    // ---- asynchronous reset mid-operation, then back-pressure
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("async_rst_count", {29'b0, fifo_count}, 32'd0);
    chk("async_rst_mem_addr", {26'b0, mem_addr}, 32'd0);
    chk("async_rst_starve", starve_cnt, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();  // first valid
    chk("bp_first_valid", {31'b0, inst_valid}, 32'd1);
    inst_ready = 1'b0;
    repeat (3) tick();
    chk("bp_full_count", {29'b0, fifo_count}, 32'd4);
    chk("bp_full_mem_addr", {26'b0, mem_addr}, 32'd4);
    repeat (7) tick();
    chk("bp_hold_count", {29'b0, fifo_count}, 32'd4);
    chk("bp_hold_mem_addr", {26'b0, mem_addr}, 32'd4);
    chk("bp_hold_pc", inst_pc, 32'd0);
    chk("bp_hold_inst", instruction, 32'h1000_0000);
    inst_ready = 1'b1;
    tick();
    chk("bp_release_pc", inst_pc, 32'd4);
    repeat (6) tick();

    // ---- redirect to 0x40 with 3 buffered + 1 pending
    rst = 1'b0;
    tick();
    rst = 1'b1; inst_ready = 1'b0;
    repeat (4) tick();
    chk("pre_redir_count", {29'b0, fifo_count}, 32'd3);
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    chk("r40_flush_count", {29'b0, fifo_count}, 32'd0);
    chk("r40_misaligned", {31'b0, misaligned}, 32'd0);
    chk("r40_mem_addr", {26'b0, mem_addr}, 32'd16);
    tick();
    chk("r40_e1_valid", {31'b0, inst_valid}, 32'd0);
    chk("r40_e1_mem_addr", {26'b0, mem_addr}, 32'd17);
    tick();
    chk("r40_e2_valid", {31'b0, inst_valid}, 32'd1);
    chk("r40_e2_pc", inst_pc, 32'h40);
    chk("r40_e2_inst", instruction, 32'h1000_0010);
    inst_ready = 1'b1;
    repeat (3) tick();

    // ---- misaligned redirect to 0x42 while streaming
    redirect = 1'b1; redirect_pc = 32'h0000_0042;
    tick();
    redirect = 1'b0;
    chk("r42_mis_pulse", {31'b0, misaligned}, 32'd1);
    chk("r42_mem_addr", {26'b0, mem_addr}, 32'd16);
    chk("r42_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("r42_mis_drop", {31'b0, misaligned}, 32'd0);
    chk("r42_e1_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("r42_e2_pc", inst_pc, 32'h40);
    chk("r42_starve", starve_cnt, starve_exp(32'd2));
    repeat (3) tick();

    // ---- redirect with coinciding pop, held for two cycles
    chk("r2_pre_valid", {31'b0, inst_valid}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0080;
    tick();
    chk("r2_c1_valid", {31'b0, inst_valid}, 32'd0);
    redirect_pc = 32'h0000_00C0;
    tick();
    redirect = 1'b0;
    chk("r2_c2_valid", {31'b0, inst_valid}, 32'd0);
    chk("r2_mem_addr", {26'b0, mem_addr}, 32'd48);
    tick();
    chk("r2_e1_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("r2_e2_valid", {31'b0, inst_valid}, 32'd1);
    chk("r2_e2_pc", inst_pc, 32'hC0);
    chk("r2_e2_inst", instruction, 32'h1000_0030);
    chk("r2_starve", starve_cnt, starve_exp(32'd5));
    repeat (4) tick();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
